channel_inst_receiver: RTL

Channel-side receiver for the instruction pulses and sampling-clock enable produced by the SPI instruction driver. It synchronizes the asynchronous `inst_rst` / `inst_readout` / `inst_start` pulses and the `clk_enable` level into the channel readout clock domain. It runs the channel clear sequence and reads the sample memory out in trigger order over a valid/ready stream toward the SPI readback path.

---
 rtl/channel_inst_receiver.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/channel_inst_receiver.sv
// channel_inst_receiver
// Receives the SPI driver's asynchronous instruction pulses and sampling-enable
// level in the channel readout clock domain. It runs the channel clear
// sequence, tracks the stop pointer of the last sampling window, and streams
// the sample memory out in trigger order, oldest sample first.
//
// Stream handshake: a word transfers on a rising edge where rd_valid and
// rd_ready are both high. Once rd_valid is raised, rd_data and rd_last hold
// steady until that transfer. rd_valid does not depend on rd_ready. The only
// way a word is withdrawn without a transfer is an abort (reset command or rstn).
module channel_inst_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 256,
  parameter int DATA_W      = 8,
  parameter int CLR_CYCLES  = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inst_rst,
  input  logic              inst_readout,
  input  logic              inst_start,
  input  logic              clk_enable,
  input  logic [AW-1:0]     wr_ptr,
  output logic [AW-1:0]     mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ch_clear,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              busy,
  output logic              cmd_drop,
  output logic [2:0]        dbg_state
);

  // Width of the clear-cycle counter; it counts 0 .. CLR_CYCLES-1.
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  // Bit positions of the asynchronous inputs inside the synchronizer bus.
  localparam int B_RST = 0;
  localparam int B_RDO = 1;
  localparam int B_STA = 2;
  localparam int B_EN  = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CLEAR   = 3'd2,
    S_FETCH   = 3'd3,
    S_CAPTURE = 3'd4,
    S_OUT     = 3'd5
  } state_t;

  state_t              r_state;
  logic [3:0]          r_sync [SYNC_STAGES];
  logic [3:0]          r_edge_d;
  logic [AW-1:0]       r_stop_q;
  logic [AW-1:0]       r_base;
  logic [AW-1:0]       r_cnt;
  logic [AW-1:0]       r_mem_addr;
  logic [CW-1:0]       r_clr_cnt;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_rd_last;
  logic                r_ch_clear;
  logic                r_busy;
  logic                r_cmd_drop;

  logic [3:0]          w_sync;
  logic                w_rst_e;
  logic                w_rdo_e;
  logic                w_sta_e;
  logic                w_en_rise;
  logic                w_en_fall;
  logic                w_en_lvl;
  logic [AW-1:0]       w_base;
  logic                w_is_last;

  // Synchronizer chain: all four async inputs shift through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= {clk_enable, inst_start, inst_readout, inst_rst};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // One extra register behind the synchronizer for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_edge_d <= '0;
    end else begin
      r_edge_d <= w_sync;
    end
  end

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_rst_e   = w_sync[B_RST] & ~r_edge_d[B_RST];
  assign w_rdo_e   = w_sync[B_RDO] & ~r_edge_d[B_RDO];
  assign w_sta_e   = w_sync[B_STA] & ~r_edge_d[B_STA];
  assign w_en_rise = w_sync[B_EN]  & ~r_edge_d[B_EN];
  assign w_en_fall = ~w_sync[B_EN] &  r_edge_d[B_EN];
  assign w_en_lvl  = w_sync[B_EN];

  // The oldest sample sits one past the stop pointer (wraps modulo DEPTH).
  assign w_base    = r_stop_q + AW'(1);
  assign w_is_last = (r_cnt == LAST_IDX);

  // Stop pointer: every end of a sampling window records where writing stopped,
  // whatever the readout state machine is doing at the time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stop_q <= '0;
    end else if (w_en_fall) begin
      r_stop_q <= wr_ptr;
    end
  end

  // Command / readout state machine with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_mem_addr <= '0;
      r_base     <= '0;
      r_cnt      <= '0;
      r_clr_cnt  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_ch_clear <= 1'b0;
      r_busy     <= 1'b0;
      r_cmd_drop <= 1'b0;
    end else if (w_rst_e) begin
      // Reset command wins over everything, in any state, and restarts a
      // clear already in progress. Any word on the stream is withdrawn.
      r_state    <= S_CLEAR;
      r_ch_clear <= 1'b1;
      r_clr_cnt  <= '0;
      r_busy     <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_cnt      <= '0;
      r_cmd_drop <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rdo_e) begin
            r_state    <= S_FETCH;
            r_busy     <= 1'b1;
            r_base     <= w_base;
            r_mem_addr <= w_base;
            r_cnt      <= '0;
            // A start edge arriving together with the readout loses.
            if (w_sta_e) begin
              r_cmd_drop <= 1'b1;
            end
          end else if (w_en_rise) begin
            r_state <= S_ARMED;
          end
        end

        S_ARMED: begin
          // Readout is refused while sampling is running.
          if (w_rdo_e) begin
            r_cmd_drop <= 1'b1;
          end
          if (w_en_fall) begin
            r_state <= S_IDLE;
          end
        end

        S_CLEAR: begin
          // Readout/start edges are silently ignored during a clear.
          if (r_clr_cnt == CLR_LAST) begin
            r_ch_clear <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= w_en_lvl ? S_ARMED : S_IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + CW'(1);
          end
        end

        S_FETCH: begin
          // mem_addr was registered last cycle; the RAM reads it this edge.
          if (w_rdo_e || w_sta_e) begin
            r_cmd_drop <= 1'b1;
          end
          r_state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          if (w_rdo_e || w_sta_e) begin
            r_cmd_drop <= 1'b1;
          end
          r_rd_data  <= mem_rdata;
          r_rd_valid <= 1'b1;
          r_rd_last  <= w_is_last;
          r_state    <= S_OUT;
        end

        S_OUT: begin
          if (w_rdo_e || w_sta_e) begin
            r_cmd_drop <= 1'b1;
          end
          if (r_rd_valid && rd_ready) begin
            r_rd_valid <= 1'b0;
            if (w_is_last) begin
              r_rd_last <= 1'b0;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_cnt      <= r_cnt + AW'(1);
              r_mem_addr <= r_base + r_cnt + AW'(1);
              r_state    <= S_FETCH;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign ch_clear  = r_ch_clear;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;
  assign busy      = r_busy;
  assign cmd_drop  = r_cmd_drop;
  assign dbg_state = r_state;

endmodule
